// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline definitions: MEM-stage FSM states and the bit positions
// used when stall/flush controls are handled as vectors.
package mem_stage_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam int STALL_IF  = 0;
  localparam int STALL_ID  = 1;
  localparam int STALL_EXE = 2;
  localparam int STALL_MEM = 3;

  localparam int FLUSH_ID  = 0;
  localparam int FLUSH_EXE = 1;
  localparam int FLUSH_MEM = 2;
  localparam int FLUSH_WB  = 3;

endpackage

// File: rtl/mem_stage_ctrl_hazard.sv
// Load-use comparator: flags an ID-stage instruction that reads the
// destination of a load still sitting in EXE.
module hazard_detect (
  input  logic       is_load_exe,
  input  logic       we_reg_exe,
  input  logic [4:0] rd_exe,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       use_rs1_id,
  input  logic       use_rs2_id,
  output logic       lu
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign rs1_hit = use_rs1_id && (rs1_id == rd_exe);
  assign rs2_hit = use_rs2_id && (rs2_id == rd_exe);
  assign lu      = is_load_exe && we_reg_exe && (rd_exe != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: data-memory handshake FSM, pipeline stall/flush
// arbitration and stall-cycle counter. Optional watchdog: MEM_TIMEOUT_EN.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_mem,
  input  logic        is_load_mem,
  input  logic        we_mem_mem,
  input  logic        except_happen_mem,
  input  logic        dmem_ack,
  input  logic        is_load_exe,
  input  logic        we_reg_exe,
  input  logic [4:0]  rd_exe,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        use_rs1_id,
  input  logic        use_rs2_id,
  input  logic        redirect_exe,
  input  logic        trap_mem,
  output logic        dmem_req,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_exe,
  output logic        stall_mem,
  output logic        flush_id,
  output logic        flush_exe,
  output logic        flush_mem,
  output logic        flush_wb,
  output logic        mem_fault,
  output logic [31:0] stall_cnt
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  mem_state_e state, state_n;
  logic       acc, acc_eff, lu;
  logic       req_c, mem_stall, mem_hold, timeout_hit;
  logic [3:0] stall_v, flush_v;

  hazard_detect u_hazard (
    .is_load_exe (is_load_exe),
    .we_reg_exe  (we_reg_exe),
    .rd_exe      (rd_exe),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .use_rs1_id  (use_rs1_id),
    .use_rs2_id  (use_rs2_id),
    .lu          (lu)
  );

  assign acc = valid_mem && (is_load_mem || we_mem_mem) && !except_happen_mem;
  // After a timeout the faulting access is still presented; hold it off for the fault cycle.
  assign acc_eff = acc && !mem_fault;

  always_comb begin
    // NOTE: defaults first so no branch leaves a signal unassigned (no latches).
    state_n   = state;
    req_c     = 1'b0;
    mem_stall = 1'b0;
    case (state)
      IDLE: begin
        req_c = acc_eff;
        if (acc_eff && !dmem_ack) begin
          mem_stall = 1'b1;
          state_n   = WAIT;
        end
      end
      WAIT: begin
        req_c = 1'b1;
        if (dmem_ack) begin
          state_n = IDLE;
        end else begin
          mem_stall = 1'b1;
          if (timeout_hit) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // WAIT suppresses flushes even in the ack cycle; held registers re-present the event next cycle.
  assign mem_hold = (state == WAIT) || mem_stall;

  always_comb begin
    stall_v = '0;
    flush_v = '0;
    if (mem_hold) begin
      stall_v = {4{mem_stall}};
    end else if (trap_mem) begin
      flush_v[FLUSH_ID]  = 1'b1;
      flush_v[FLUSH_EXE] = 1'b1;
      flush_v[FLUSH_MEM] = 1'b1;
    end else if (redirect_exe) begin
      flush_v[FLUSH_ID]  = 1'b1;
      flush_v[FLUSH_EXE] = 1'b1;
    end else if (lu) begin
      stall_v[STALL_IF]  = 1'b1;
      stall_v[STALL_ID]  = 1'b1;
      flush_v[FLUSH_EXE] = 1'b1;
    end
    if (!rst_n) begin
      stall_v = '0;
      flush_v = '0;
    end
  end

  assign dmem_req  = rst_n && req_c;
  assign stall_if  = stall_v[STALL_IF];
  assign stall_id  = stall_v[STALL_ID];
  assign stall_exe = stall_v[STALL_EXE];
  assign stall_mem = stall_v[STALL_MEM];
  assign flush_id  = flush_v[FLUSH_ID];
  assign flush_exe = flush_v[FLUSH_EXE];
  assign flush_mem = flush_v[FLUSH_MEM];
  assign flush_wb  = flush_v[FLUSH_WB];

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state     <= IDLE;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      if (stall_if && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt    <= '0;
      mem_fault <= 1'b0;
    end else begin
      mem_fault <= (state == WAIT) && !dmem_ack && timeout_hit;
      if ((state == WAIT) && (state_n == WAIT)) to_cnt <= to_cnt + TO_W'(1);
      else                                      to_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign mem_fault   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl; timeout scenario runs when
// MEM_TIMEOUT_EN is defined (instance built with TIMEOUT_CYCLES = 4).
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic valid_mem, is_load_mem, we_mem_mem, except_happen_mem, dmem_ack;
  logic is_load_exe, we_reg_exe, use_rs1_id, use_rs2_id, redirect_exe, trap_mem;
  logic [4:0] rd_exe, rs1_id, rs2_id;
  logic dmem_req, stall_if, stall_id, stall_exe, stall_mem;
  logic flush_id, flush_exe, flush_mem, flush_wb, mem_fault;
  logic [31:0] stall_cnt;
  logic [9:0] ctl;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_mem(valid_mem), .is_load_mem(is_load_mem), .we_mem_mem(we_mem_mem),
    .except_happen_mem(except_happen_mem), .dmem_ack(dmem_ack),
    .is_load_exe(is_load_exe), .we_reg_exe(we_reg_exe), .rd_exe(rd_exe),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .redirect_exe(redirect_exe), .trap_mem(trap_mem),
    .dmem_req(dmem_req), .stall_if(stall_if), .stall_id(stall_id),
    .stall_exe(stall_exe), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_exe(flush_exe), .flush_mem(flush_mem), .flush_wb(flush_wb),
    .mem_fault(mem_fault), .stall_cnt(stall_cnt)
  );

  // {req, s_if, s_id, s_exe, s_mem, f_id, f_exe, f_mem, f_wb, fault}
  assign ctl = {dmem_req, stall_if, stall_id, stall_exe, stall_mem,
                flush_id, flush_exe, flush_mem, flush_wb, mem_fault};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    valid_mem = 0; is_load_mem = 0; we_mem_mem = 0; except_happen_mem = 0; dmem_ack = 0;
    is_load_exe = 0; we_reg_exe = 0; rd_exe = 0; rs1_id = 0; rs2_id = 0;
    use_rs1_id = 0; use_rs2_id = 0; redirect_exe = 0; trap_mem = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    clear_inputs();
    valid_mem = 1; is_load_mem = 1; trap_mem = 1; redirect_exe = 1;
    is_load_exe = 1; we_reg_exe = 1; rd_exe = 5'd3; rs1_id = 5'd3; use_rs1_id = 1;
    #12;
    vectors++; if (ctl !== 10'b0) begin miscompares++; $display("FAIL reset_ctl: got %b want %b", ctl, 10'b0); end
    vectors++; if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    clear_inputs();
    tick();
    rst_n = 1;
    #1;
    vectors++; if (ctl !== 10'b0) begin miscompares++; $display("FAIL post_reset_ctl: got %b want %b", ctl, 10'b0); end
  endtask

  task automatic test_load_ack;
    valid_mem = 1; is_load_mem = 1; dmem_ack = 1;
    #1;
    vectors++; if (ctl !== 10'b1000000000) begin miscompares++; $display("FAIL load_ack_req: got %b want %b", ctl, 10'b1000000000); end
    tick();
    clear_inputs();
    #1;
    vectors++; if (ctl !== 10'b0) begin miscompares++; $display("FAIL load_ack_after: got %b want %b", ctl, 10'b0); end
    vectors++; if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL load_ack_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_store_late;
    valid_mem = 1; we_mem_mem = 1; dmem_ack = 0;
    #1;
    vectors++; if (ctl !== 10'b1111100000) begin miscompares++; $display("FAIL store_c0: got %b want %b", ctl, 10'b1111100000); end
    for (int i = 1; i < 3; i++) begin
      tick();
      vectors++; if (ctl !== 10'b1111100000) begin miscompares++; $display("FAIL store_c%0d: got %b want %b", i, ctl, 10'b1111100000); end
      vectors++; if (dut.state !== WAIT) begin miscompares++; $display("FAIL store_state_c%0d: got %0d want WAIT", i, dut.state); end
    end
    tick();
    dmem_ack = 1;
    #1;
    vectors++; if (ctl !== 10'b1000000000) begin miscompares++; $display("FAIL store_ack: got %b want %b", ctl, 10'b1000000000); end
    tick();
    clear_inputs();
    #1;
    vectors++; if (ctl !== 10'b0) begin miscompares++; $display("FAIL store_done: got %b want %b", ctl, 10'b0); end
    vectors++; if (dut.state !== IDLE) begin miscompares++; $display("FAIL store_idle: got %0d want IDLE", dut.state); end
    vectors++; if (stall_cnt !== 32'd3) begin miscompares++; $display("FAIL store_cnt: got %0d want 3", stall_cnt); end
  endtask

  task automatic test_load_use;
    is_load_exe = 1; we_reg_exe = 1; rd_exe = 5'd5; rs1_id = 5'd0; use_rs1_id = 1;
    rs2_id = 5'd5; use_rs2_id = 1;
    #1;
    vectors++; if (ctl !== 10'b0110001000) begin miscompares++; $display("FAIL lu_hit: got %b want %b", ctl, 10'b0110001000); end
    tick();
    is_load_exe = 0; we_reg_exe = 0;
    #1;
    vectors++; if (ctl !== 10'b0) begin miscompares++; $display("FAIL lu_bubble: got %b want %b", ctl, 10'b0); end
    vectors++; if (stall_cnt !== 32'd4) begin miscompares++; $display("FAIL lu_cnt: got %0d want 4", stall_cnt); end
    is_load_exe = 1; we_reg_exe = 1; rd_exe = 5'd0; rs1_id = 5'd0; rs2_id = 5'd0;
    #1;
    vectors++; if (ctl !== 10'b0) begin miscompares++; $display("FAIL lu_x0: got %b want %b", ctl, 10'b0); end
    rd_exe = 5'd7; rs2_id = 5'd7; use_rs2_id = 0;
    #1;
    vectors++; if (ctl !== 10'b0) begin miscompares++; $display("FAIL lu_unused: got %b want %b", ctl, 10'b0); end
    clear_inputs();
    tick();
  endtask

  task automatic test_trap_redirect;
    trap_mem = 1; redirect_exe = 1;
    is_load_exe = 1; we_reg_exe = 1; rd_exe = 5'd9; rs1_id = 5'd9; use_rs1_id = 1;
    #1;
    vectors++; if (ctl !== 10'b0000011100) begin miscompares++; $display("FAIL trap_redir: got %b want %b", ctl, 10'b0000011100); end
    trap_mem = 0;
    #1;
    vectors++; if (ctl !== 10'b0000011000) begin miscompares++; $display("FAIL redir_only: got %b want %b", ctl, 10'b0000011000); end
    tick();
    clear_inputs();
    #1;
    vectors++; if (ctl !== 10'b0) begin miscompares++; $display("FAIL trap_after: got %b want %b", ctl, 10'b0); end
  endtask

  task automatic test_redirect_wait;
    valid_mem = 1; is_load_mem = 1; dmem_ack = 0; redirect_exe = 1;
    #1;
    vectors++; if (ctl !== 10'b1111100000) begin miscompares++; $display("FAIL rw_enter: got %b want %b", ctl, 10'b1111100000); end
    tick();
    vectors++; if (ctl !== 10'b1111100000) begin miscompares++; $display("FAIL rw_wait: got %b want %b", ctl, 10'b1111100000); end
    tick();
    dmem_ack = 1;
    #1;
    vectors++; if (ctl !== 10'b1000000000) begin miscompares++; $display("FAIL rw_ack: got %b want %b", ctl, 10'b1000000000); end
    tick();
    valid_mem = 0; is_load_mem = 0; dmem_ack = 0;
    #1;
    vectors++; if (ctl !== 10'b0000011000) begin miscompares++; $display("FAIL rw_flush: got %b want %b", ctl, 10'b0000011000); end
    vectors++; if (stall_cnt !== 32'd6) begin miscompares++; $display("FAIL rw_cnt: got %0d want 6", stall_cnt); end
    clear_inputs();
    tick();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    valid_mem = 1; is_load_mem = 1; dmem_ack = 0;
    #1;
    vectors++; if (ctl !== 10'b1111100000) begin miscompares++; $display("FAIL to_enter: got %b want %b", ctl, 10'b1111100000); end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (ctl !== 10'b1111100000) begin miscompares++; $display("FAIL to_wait%0d: got %b want %b", i, ctl, 10'b1111100000); end
    end
    tick();
    vectors++; if (ctl !== 10'b0000000001) begin miscompares++; $display("FAIL to_fault: got %b want %b", ctl, 10'b0000000001); end
    vectors++; if (dut.state !== IDLE) begin miscompares++; $display("FAIL to_idle: got %0d want IDLE", dut.state); end
    clear_inputs();
    tick();
    vectors++; if (ctl !== 10'b0) begin miscompares++; $display("FAIL to_after: got %b want %b", ctl, 10'b0); end
    vectors++; if (stall_cnt !== 32'd11) begin miscompares++; $display("FAIL to_cnt: got %0d want 11", stall_cnt); end
  endtask
`endif

  task automatic test_reset_in_wait;
    valid_mem = 1; we_mem_mem = 1; dmem_ack = 0;
    tick();
    vectors++; if (dut.state !== WAIT) begin miscompares++; $display("FAIL rst_wait_state: got %0d want WAIT", dut.state); end
    rst_n = 0;
    #1;
    vectors++; if (ctl !== 10'b0) begin miscompares++; $display("FAIL rst_wait_ctl: got %b want %b", ctl, 10'b0); end
    vectors++; if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL rst_wait_cnt: got %0d want 0", stall_cnt); end
    tick();
    rst_n = 1;
    dmem_ack = 1;
    #1;
    vectors++; if (dut.state !== IDLE) begin miscompares++; $display("FAIL rst_rel_state: got %0d want IDLE", dut.state); end
    vectors++; if (ctl !== 10'b1000000000) begin miscompares++; $display("FAIL rst_rel_ctl: got %b want %b", ctl, 10'b1000000000); end
    tick();
    clear_inputs();
    #1;
    vectors++; if (ctl !== 10'b0) begin miscompares++; $display("FAIL rst_rel_done: got %b want %b", ctl, 10'b0); end
    vectors++; if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL rst_rel_cnt: got %0d want 0", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_ack();
    test_store_late();
    test_load_use();
    test_trap_redirect();
    test_redirect_wait();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 256, giving the data-memory wait-cycle limit (used only under MEM_TIMEOUT_EN).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 The block SHALL have these inputs:
- valid_mem  in  1  the MEM-stage instruction is valid.
- is_load_mem, we_mem_mem  in  1 each  the MEM-stage instruction is a load or a store.
- except_happen_mem  in  1  the MEM-stage instruction already carries an exception.
- dmem_ack  in  1  data-memory completion.
REQ-004 The block SHALL have these hazard and redirect inputs:
- is_load_exe, we_reg_exe  in  1 each  EXE-stage instruction control.
- rd_exe  in  5  EXE-stage destination register.
- rs1_id, rs2_id  in  5 each  ID-stage source registers.
- use_rs1_id, use_rs2_id  in  1 each  ID-stage source-register-used flags.
- redirect_exe  in  1  branch or jump redirect from EXE.
- trap_mem  in  1  trap or xret commit in MEM.
REQ-005 The block SHALL have these outputs:
- dmem_req  out  1  data-memory request.
- stall_if, stall_id, stall_exe, stall_mem  out  1 each  pipeline-register holds.
- flush_id, flush_exe, flush_mem, flush_wb  out  1 each  pipeline-register bubbles.
- mem_fault  out  1  one-cycle timeout pulse.
- stall_cnt  out  32  count of stalled cycles.

Function
REQ-006 The FSM SHALL have two states, IDLE and WAIT.
REQ-007 An access SHALL be defined as acc = valid_mem & (is_load_mem | we_mem_mem) & ~except_happen_mem.
REQ-008 In IDLE, dmem_req SHALL equal acc (combinational).
REQ-009 In IDLE, acc & dmem_ack SHALL complete the access with zero stall cycles, and the FSM SHALL stay in IDLE.
REQ-010 In IDLE, acc & ~dmem_ack SHALL assert all four stall outputs in that same cycle and move the FSM to WAIT.
REQ-011 In WAIT, dmem_req and all four stalls SHALL stay at 1.
REQ-012 In WAIT, dmem_ack SHALL drop all stalls in that same cycle and return the FSM to IDLE, so that EXE/MEM and MEM/WB advance on that edge.
REQ-013 A load-use hazard SHALL be defined as lu = is_load_exe & we_reg_exe & (rd_exe != 0) & ((use_rs1_id & rs1_id == rd_exe) | (use_rs2_id & rs2_id == rd_exe)).
REQ-014 On lu, the block SHALL assert stall_if, stall_id and flush_exe, inserting exactly one bubble.
REQ-015 On redirect_exe, the block SHALL assert flush_id and flush_exe.
REQ-016 On trap_mem, the block SHALL assert flush_id, flush_exe and flush_mem.
REQ-017 Events SHALL be prioritised as follows:
- memory stall (WAIT, or IDLE with acc & ~dmem_ack) first;
- then trap_mem;
- then redirect_exe;
- then lu.
REQ-018 While a memory stall is active, trap_mem, redirect_exe and lu SHALL produce no flush; they are re-evaluated once the stall releases, because the held registers re-present them.
REQ-019 flush_wb SHALL be driven to 0 and is reserved.
REQ-020 A flush SHALL never be asserted on a register whose stall is asserted in the same cycle, except stall_id with flush_exe under lu.
REQ-021 stall_cnt SHALL increment by 1 on every cycle in which stall_if = 1 and SHALL saturate at 0xFFFFFFFF.

Reset
REQ-022 While rst_n = 0, the FSM SHALL be in IDLE, stall_cnt SHALL be 0, the timeout counter SHALL be 0 and mem_fault SHALL be 0.
REQ-023 While rst_n = 0, all stall and flush outputs and dmem_req SHALL be 0, regardless of the inputs.
REQ-024 Reset asserted in WAIT SHALL abandon the access immediately; the next access after release SHALL start from IDLE.

Configuration
REQ-025 With MEM_TIMEOUT_EN defined, a counter SHALL count WAIT cycles.
REQ-026 With MEM_TIMEOUT_EN defined, when that counter reaches TIMEOUT_CYCLES - 1 without dmem_ack, the block SHALL:
- pulse mem_fault (registered) for one cycle;
- return the FSM to IDLE;
- drop dmem_req and the stalls on the following cycle.
REQ-027 With MEM_TIMEOUT_EN defined, the counter SHALL clear on entering WAIT and on leaving WAIT.
REQ-028 Without MEM_TIMEOUT_EN, the timeout counter SHALL be absent and mem_fault SHALL be tied to 0.

Structure
REQ-029 The FSM state enum and the stall/flush bit-vector index constants SHALL live in the shared pipeline package.
REQ-030 The load-use comparator SHALL be a sub-module, hazard_detect.

Verification
REQ-031 The bench SHALL cover a load in IDLE with dmem_ack in the same cycle: dmem_req = 1 for 1 cycle, no stalls, stall_cnt = 0.
REQ-032 The bench SHALL cover a store with dmem_ack 3 cycles late: stalls high for exactly 3 cycles, the FSM in WAIT, stall_cnt = 3.
REQ-033 The bench SHALL cover a load in EXE with rd_exe = 5 and rs2_id = 5, use_rs2_id = 1: stall_if, stall_id and flush_exe high for 1 cycle.
REQ-034 The bench SHALL cover trap_mem and redirect_exe in the same cycle with no memory stall: flush_id, flush_exe and flush_mem high for 1 cycle.
REQ-035 The bench SHALL cover redirect_exe during WAIT: no flush; the flush appears in the cycle after dmem_ack.
REQ-036 With MEM_TIMEOUT_EN defined and TIMEOUT_CYCLES = 4, the bench SHALL withhold dmem_ack: one mem_fault pulse, the FSM returns to IDLE, the stalls drop; rst_n pulsed low in WAIT SHALL clear the outputs immediately.
